// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier between num_req requesters.
// Define FP_ARB_TIMEOUT_EN to enable the ISSUE/WAIT watchdog and out_err.
module fp_mult_arbiter #(
    parameter int num_req    = 4,
    parameter int cell_width = 32,
    parameter int timeout    = 1023
) (
    input  logic                          in_clk,
    input  logic                          in_reset,
    input  logic [num_req-1:0]            in_req,
    input  logic [num_req*cell_width-1:0] in_a,
    input  logic [num_req*cell_width-1:0] in_b,
    input  logic [num_req-1:0]            in_ack,
    output logic [num_req-1:0]            out_done,
    output logic [cell_width-1:0]         out_z,
    output logic                          out_busy,
    output logic                          out_err,
    output logic [cell_width-1:0]         mult_a,
    output logic [cell_width-1:0]         mult_b,
    output logic                          mult_a_stb,
    output logic                          mult_b_stb,
    output logic                          mult_z_ack,
    output logic                          mult_rst,
    input  logic [cell_width-1:0]         mult_z,
    input  logic                          mult_z_stb,
    input  logic                          mult_a_ack,
    input  logic                          mult_b_ack
);

    localparam int IW = (num_req > 1) ? $clog2(num_req) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   last_grant;
    logic            rst_hold;
    logic            tmo_hit;

    logic                  found;
    logic [IW-1:0]         pick;
    logic [cell_width-1:0] pick_a;
    logic [cell_width-1:0] pick_b;
    int                    idx;

    // Scan downward so the nearest requester after last_grant wins.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        pick_a = '0;
        pick_b = '0;
        idx    = 0;
        for (int k = num_req; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % num_req;
            if (in_req[idx]) begin
                found  = 1'b1;
                pick   = IW'(idx);
                pick_a = in_a[idx*cell_width +: cell_width];
                pick_b = in_b[idx*cell_width +: cell_width];
            end
        end
    end

`ifdef FP_ARB_TIMEOUT_EN
    localparam int TW = $clog2(timeout + 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE || state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == ISSUE || state == WAIT)
                  && (tmo_cnt == TW'(timeout - 1));
`else
    logic unused_cfg;

    assign unused_cfg = (timeout != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(num_req - 1);
            rst_hold   <= 1'b0;
            out_done   <= '0;
            out_z      <= '0;
            out_busy   <= 1'b0;
            out_err    <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            mult_a_stb <= 1'b0;
            mult_b_stb <= 1'b0;
            mult_z_ack <= 1'b0;
            mult_rst   <= 1'b1;
        end else begin
            mult_z_ack <= 1'b0;
            // rst_hold stretches a watchdog flush to two cycles.
            if (rst_hold) begin
                rst_hold <= 1'b0;
            end else begin
                mult_rst <= 1'b0;
            end

            if (tmo_hit) begin
                mult_rst        <= 1'b1;
                rst_hold        <= 1'b1;
                mult_a_stb      <= 1'b0;
                mult_b_stb      <= 1'b0;
                out_err         <= 1'b1;
                out_done        <= '0;
                out_done[grant] <= 1'b1;
                out_z           <= cell_width'(32'h7FC0_0000);
                state           <= DONE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (found) begin
                            grant      <= pick;
                            mult_a     <= pick_a;
                            mult_b     <= pick_b;
                            mult_a_stb <= 1'b1;
                            mult_b_stb <= 1'b1;
                            out_busy   <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (mult_a_ack) mult_a_stb <= 1'b0;
                        if (mult_b_ack) mult_b_stb <= 1'b0;
                        if ((!mult_a_stb || mult_a_ack)
                            && (!mult_b_stb || mult_b_ack)) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (mult_z_stb) begin
                            out_z           <= mult_z;
                            mult_z_ack      <= 1'b1;
                            out_done        <= '0;
                            out_done[grant] <= 1'b1;
                            state           <= DONE;
                        end
                    end
                    DONE: begin
                        if (in_ack[grant]) begin
                            out_done   <= '0;
                            out_err    <= 1'b0;
                            out_busy   <= 1'b0;
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
